// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^N) reduction slice.
//   - state_t       : reducer FSM states
//   - GF_N/GF_POLY  : default field (AES field, x^8+x^4+x^3+x+1)
//   - GF_N_SMALL/GF_POLY_SMALL : tiny GF(4) build for quick checks
//   - poly_ok()     : true when the modulus has its degree-N term set
package gf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int         GF_N          = 8;
    localparam logic [8:0] GF_POLY       = 9'h11B;
    localparam int         GF_N_SMALL    = 2;
    localparam logic [2:0] GF_POLY_SMALL = 3'b111;

    // A modulus without x^N would not be degree N, so the reduction
    // would leave bits at or above N behind.
    function automatic logic poly_ok(input int n, input logic [31:0] poly);
        return poly[n];
    endfunction

endpackage

// File: rtl/gf_mod_reduce_if.sv
// Handshake bundle between the carry-less multiplier and the reducer.
//   in_valid/in_ready/in_prod   : unreduced (2N-1)-bit product in
//   out_valid/out_ready/out_rem : N-bit field element out
// master = producer/consumer side (drives in_*, out_ready)
// slave  = reducer side
interface gf_mod_reduce_if #(
    parameter int N = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2*N-2:0]   in_prod;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_rem;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_rem
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_rem
    );
endinterface

// File: rtl/gf_reduce_step.sv
// One reduction step: clears coefficient x^(N+k) of r by folding in
// POLY shifted up by k. Purely combinational so it can be chained
// for an unrolled or pipelined reducer.
//   r      : working polynomial (2N-1 bits)
//   k      : step index, 0..N-2
//   r_next : r ^ (r[N+k] ? POLY<<k : 0)
module gf_reduce_step #(
    parameter int         N    = 8,
    parameter logic [N:0] POLY = 9'h11B,
    parameter int         KW   = $clog2(N)
) (
    input  logic [2*N-2:0] r,
    input  logic [KW-1:0]  k,
    output logic [2*N-2:0] r_next
);
    localparam int W  = 2*N-1;
    localparam int IW = $clog2(W);

    logic [W-1:0]  poly_sh;
    logic [IW-1:0] idx;

    assign poly_sh = W'(POLY) << k;
    assign idx     = IW'(N) + IW'(k);
    assign r_next  = r[idx] ? (r ^ poly_sh) : r;

endmodule

// File: rtl/gf_mod_reduce.sv
// Iterative GF(2^N) modular reducer. Accepts an unreduced carry-less
// product, reduces it one coefficient per clock (MSB first, N-1 steps,
// fixed latency) and presents in_prod mod POLY until consumed.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of gf_mod_reduce_if (in_* request, out_* result)
// All outputs decode from registers only; no in_* -> out_* path.
module gf_mod_reduce
    import gf_pkg::*;
#(
    parameter int         N    = GF_N,
    parameter logic [N:0] POLY = GF_POLY
) (
    input  logic             clk,
    input  logic             rst,
    gf_mod_reduce_if.slave   bus
);
    localparam int KW = $clog2(N);

    if (!poly_ok(N, 32'(POLY))) begin : g_bad_poly
        $error("gf_mod_reduce: POLY must have bit N set");
    end

    state_t          state, state_nxt;
    logic [2*N-2:0]  r, r_nxt, r_step;
    logic [KW-1:0]   k, k_nxt;

    gf_reduce_step #(
        .N    (N),
        .POLY (POLY),
        .KW   (KW)
    ) u_step (
        .r      (r),
        .k      (k),
        .r_next (r_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r     <= '0;
            k     <= '0;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
            k     <= k_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        k_nxt     = k;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    r_nxt     = bus.in_prod;
                    k_nxt     = KW'(N-2);
                    state_nxt = REDUCE;
                end
            end
            REDUCE: begin
                // Every step runs even when the bit is already clear,
                // keeping latency independent of the data.
                r_nxt = r_step;
                if (k == '0) state_nxt = DONE;
                else         k_nxt     = k - 1'b1;
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    // Visible in every state; only meaningful while out_valid is high.
    assign bus.out_rem   = r[N-1:0];

endmodule
